// File: rtl/debug_command_control_pkg.sv
// Shared definitions for the debug command sequencer: one-hot FSM states,
// UART command bytes and the end-of-program sentinel word.
package debug_command_control_pkg;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_LOAD  = 6'b000010,
    ST_RUN   = 6'b000100,
    ST_STEP  = 6'b001000,
    ST_PULSE = 6'b010000,
    ST_SEND  = 6'b100000
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [31:0] SENTINEL_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_command_control_assembler.sv
// Packs incoming UART bytes MSB first into instruction words and flags each
// completed word with a one-cycle word_valid pulse.
module debug_command_control_assembler
  import debug_command_control_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  valid_q, valid_d;

  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (clear) begin
      count_d = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], byte_in};
      count_d = (count_q == LAST_BYTE) ? '0 : count_q + 1'b1;
      valid_d = (count_q == LAST_BYTE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // The shift register already holds the finished word during the strobe cycle.
  assign word       = shift_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/debug_command_control.sv
// Debug command sequencer: decodes UART commands, loads program words into
// instruction memory, gates the pipeline and requests state dumps.
module debug_command_control
  import debug_command_control_pkg::*;
#(
  parameter int IM_ADDR_LENGTH = 32,
  parameter int IM_MEM_SIZE    = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int NBITS          = 32,
  parameter int BYTE_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BYTE_WIDTH-1:0]     rx_data,
  input  logic                      rx_done,
  input  logic                      halt,
  input  logic                      send_done,
  output logic                      im_wr_en,
  output logic [IM_ADDR_LENGTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0]     im_wr_data,
  output logic                      pipe_enable,
  output logic                      send_flag,
  output logic [NBITS-1:0]          clock_count,
  output logic                      prog_loaded
);

  localparam logic [IM_ADDR_LENGTH-1:0] LAST_ADDR = IM_ADDR_LENGTH'(IM_MEM_SIZE - 1);

  state_e                    state_q, state_d;
  logic                      from_step_q, from_step_d;
  logic [IM_ADDR_LENGTH-1:0] im_addr_q, im_addr_d;
  logic                      pipe_enable_q, pipe_enable_d;
  logic                      send_flag_q, send_flag_d;
  logic [NBITS-1:0]          clock_count_q, clock_count_d;
  logic                      prog_loaded_q, prog_loaded_d;

  logic                  rx_valid;
  logic                  cmd_load, cmd_cont, cmd_step, cmd_next, cmd_exit;
  logic                  asm_clear, asm_byte_valid;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  asm_word_valid;

  // A byte arriving together with send_done is dropped.
  assign rx_valid = rx_done & ~send_done;
  assign cmd_load = rx_valid && (rx_data == BYTE_WIDTH'(CMD_LOAD));
  assign cmd_cont = rx_valid && (rx_data == BYTE_WIDTH'(CMD_CONT));
  assign cmd_step = rx_valid && (rx_data == BYTE_WIDTH'(CMD_STEP));
  assign cmd_next = rx_valid && (rx_data == BYTE_WIDTH'(CMD_NEXT));
  assign cmd_exit = rx_valid && (rx_data == BYTE_WIDTH'(CMD_EXIT));

  assign asm_clear      = (state_q == ST_IDLE) && cmd_load;
  assign asm_byte_valid = (state_q == ST_LOAD) && rx_valid;

  debug_command_control_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_valid(asm_byte_valid),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_valid(asm_word_valid)
  );

  always_comb begin
    state_d       = state_q;
    from_step_d   = from_step_q;
    im_addr_d     = im_addr_q;
    pipe_enable_d = 1'b0;
    send_flag_d   = 1'b0;
    prog_loaded_d = prog_loaded_q;
    clock_count_d = clock_count_q;
    if (pipe_enable_q && (clock_count_q != {NBITS{1'b1}})) begin
      clock_count_d = clock_count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          clock_count_d = '0;
          im_addr_d     = '0;
          prog_loaded_d = 1'b0;
          state_d       = ST_LOAD;
        end else if (cmd_cont && prog_loaded_q) begin
          pipe_enable_d = 1'b1;
          state_d       = ST_RUN;
        end else if (cmd_step && prog_loaded_q) begin
          state_d = ST_STEP;
        end
      end
      ST_LOAD: begin
        // The address advances after each strobe but never past the last IM word.
        if (asm_word_valid) begin
          if (im_addr_q != LAST_ADDR) begin
            im_addr_d = im_addr_q + 1'b1;
          end
          if ((asm_word == DATA_WIDTH'(SENTINEL_WORD)) || (im_addr_q == LAST_ADDR)) begin
            prog_loaded_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (halt) begin
          send_flag_d = 1'b1;
          from_step_d = 1'b0;
          state_d     = ST_SEND;
        end else begin
          pipe_enable_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (cmd_next) begin
          from_step_d = 1'b1;
          if (halt) begin
            send_flag_d = 1'b1;
            state_d     = ST_SEND;
          end else begin
            pipe_enable_d = 1'b1;
            state_d       = ST_PULSE;
          end
        end else if (cmd_exit) begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        send_flag_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (send_done) begin
          state_d = (from_step_q && !halt) ? ST_STEP : ST_IDLE;
        end else begin
          send_flag_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      from_step_q   <= 1'b0;
      im_addr_q     <= '0;
      pipe_enable_q <= 1'b0;
      send_flag_q   <= 1'b0;
      clock_count_q <= '0;
      prog_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      from_step_q   <= from_step_d;
      im_addr_q     <= im_addr_d;
      pipe_enable_q <= pipe_enable_d;
      send_flag_q   <= send_flag_d;
      clock_count_q <= clock_count_d;
      prog_loaded_q <= prog_loaded_d;
    end
  end

  assign im_wr_en    = asm_word_valid;
  assign im_wr_data  = asm_word;
  assign im_addr     = im_addr_q;
  assign pipe_enable = pipe_enable_q;
  assign send_flag   = send_flag_q;
  assign clock_count = clock_count_q;
  assign prog_loaded = prog_loaded_q;

endmodule

// File: tb/tb_debug_command_control.sv
// Self-checking bench for debug_command_control: a default-size instance plus
// a 4-word instance share all inputs; IM strobes are checked via a scoreboard.
module tb_debug_command_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        halt = 1'b0;
  logic        send_done = 1'b0;

  logic        im_wr_en, pipe_enable, send_flag, prog_loaded;
  logic [31:0] im_addr, im_wr_data, clock_count;
  logic        s_im_wr_en, s_pipe_enable, s_send_flag, s_prog_loaded;
  logic [31:0] s_im_addr, s_im_wr_data, s_clock_count;

  always #5 clk = ~clk;

  debug_command_control dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .halt(halt), .send_done(send_done), .im_wr_en(im_wr_en), .im_addr(im_addr),
    .im_wr_data(im_wr_data), .pipe_enable(pipe_enable), .send_flag(send_flag),
    .clock_count(clock_count), .prog_loaded(prog_loaded)
  );

  debug_command_control #(.IM_MEM_SIZE(4)) dut_s (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .halt(halt), .send_done(send_done), .im_wr_en(s_im_wr_en), .im_addr(s_im_addr),
    .im_wr_data(s_im_wr_data), .pipe_enable(s_pipe_enable), .send_flag(s_send_flag),
    .clock_count(s_clock_count), .prog_loaded(s_prog_loaded)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } load_vec_t;

  typedef struct {
    logic [7:0] rx_byte;
    logic       exp_pipe_enable;
    logic       exp_send_flag;
    logic       exp_prog_loaded;
  } idle_vec_t;

  strobe_t exp_q[$];
  strobe_t exp_s_q[$];
  int checks = 0;
  int errors = 0;
  int pushed_main = 0;
  int pushed_small = 0;
  int main_strobes = 0;
  int small_strobes = 0;
  int pe_cycles = 0;

  // Independent event counters used to catch strobes or pulses nobody asked for.
  always @(negedge clk) begin
    if (im_wr_en) main_strobes++;
    if (s_im_wr_en) small_strobes++;
    if (pipe_enable) pe_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_send_done();
    @(posedge clk);
    #1;
    send_done = 1'b1;
    @(posedge clk);
    #1;
    send_done = 1'b0;
  endtask

  task automatic pop_check(input logic is_small, input logic [31:0] addr, input logic [31:0] data);
    strobe_t e;
    if (is_small ? (exp_s_q.size() == 0) : (exp_q.size() == 0)) begin
      check(is_small ? "small_unexpected_strobe" : "main_unexpected_strobe", 64'd1, 64'd0);
    end else begin
      e = is_small ? exp_s_q.pop_front() : exp_q.pop_front();
      check(is_small ? "small_strobe_addr" : "main_strobe_addr", {32'd0, addr}, {32'd0, e.addr});
      check(is_small ? "small_strobe_data" : "main_strobe_data", {32'd0, data}, {32'd0, e.data});
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic exp_main, input logic exp_small,
                           input logic [31:0] addr_main, input logic [31:0] addr_small);
    if (exp_main) begin
      exp_q.push_back({addr_main, w});
      pushed_main++;
    end
    if (exp_small) begin
      exp_s_q.push_back({addr_small, w});
      pushed_small++;
    end
    for (int i = 3; i >= 0; i--) begin
      apply_byte(w[i*8 +: 8]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (im_wr_en) pop_check(1'b0, im_addr, im_wr_data);
      if (s_im_wr_en) pop_check(1'b1, s_im_addr, s_im_wr_data);
    end
    check("main_strobe_pending", 64'(exp_q.size()), 64'd0);
    check("small_strobe_pending", 64'(exp_s_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    load_vec_t prog1[3];
    idle_vec_t ign[6];
    int        pe_start;
    int        strobes_before;

    prog1[0] = '{word: 32'h0000_0013, addr: 32'd0};
    prog1[1] = '{word: 32'h0000_0033, addr: 32'd1};
    prog1[2] = '{word: 32'hFFFF_FFFF, addr: 32'd2};

    ign[0] = '{rx_byte: 8'h43, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};
    ign[1] = '{rx_byte: 8'h53, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};
    ign[2] = '{rx_byte: 8'h4E, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};
    ign[3] = '{rx_byte: 8'h45, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};
    ign[4] = '{rx_byte: 8'h58, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};
    ign[5] = '{rx_byte: 8'hFF, exp_pipe_enable: 1'b0, exp_send_flag: 1'b0, exp_prog_loaded: 1'b0};

    $display("[TB] reset state");
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_im_wr_en", {63'd0, im_wr_en}, 64'd0);
    check("rst_im_addr", {32'd0, im_addr}, 64'd0);
    check("rst_im_wr_data", {32'd0, im_wr_data}, 64'd0);
    check("rst_pipe_enable", {63'd0, pipe_enable}, 64'd0);
    check("rst_send_flag", {63'd0, send_flag}, 64'd0);
    check("rst_clock_count", {32'd0, clock_count}, 64'd0);
    check("rst_prog_loaded", {63'd0, prog_loaded}, 64'd0);
    check("rst_small_pipe_enable", {63'd0, s_pipe_enable}, 64'd0);

    $display("[TB] commands with no program loaded are ignored");
    pe_start = pe_cycles;
    for (int i = 0; i < 6; i++) begin
      apply_byte(ign[i].rx_byte);
      tick(1);
      check("ign_pipe_enable", {63'd0, pipe_enable}, {63'd0, ign[i].exp_pipe_enable});
      check("ign_send_flag", {63'd0, send_flag}, {63'd0, ign[i].exp_send_flag});
      check("ign_prog_loaded", {63'd0, prog_loaded}, {63'd0, ign[i].exp_prog_loaded});
    end
    check("ign_no_pulses", 64'(pe_cycles - pe_start), 64'd0);

    $display("[TB] program load with sentinel");
    apply_byte(8'h4C);
    for (int i = 0; i < 3; i++) begin
      send_word(prog1[i].word, 1'b1, 1'b1, prog1[i].addr, prog1[i].addr);
    end
    tick(1);
    check("load_prog_loaded", {63'd0, prog_loaded}, 64'd1);
    check("load_small_prog_loaded", {63'd0, s_prog_loaded}, 64'd1);

    $display("[TB] continuous run until halt");
    pe_start = pe_cycles;
    apply_byte(8'h43);
    check("run_pipe_enable_on", {63'd0, pipe_enable}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    halt = 1'b1;
    tick(1);
    check("run_pipe_enable_off", {63'd0, pipe_enable}, 64'd0);
    check("run_send_flag", {63'd0, send_flag}, 64'd1);
    tick(2);
    check("run_pe_cycles", 64'(pe_cycles - pe_start), 64'd5);
    check("run_clock_count", {32'd0, clock_count}, 64'd5);
    check("run_small_clock_count", {32'd0, s_clock_count}, 64'd5);
    apply_byte(8'h4C);
    apply_byte(8'h43);
    check("send_ignores_rx_flag", {63'd0, send_flag}, 64'd1);
    check("send_ignores_rx_loaded", {63'd0, prog_loaded}, 64'd1);
    check("send_ignores_rx_count", {32'd0, clock_count}, 64'd5);
    pulse_send_done();
    halt = 1'b0;
    check("run_send_flag_clear", {63'd0, send_flag}, 64'd0);
    check("run_small_send_flag_clear", {63'd0, s_send_flag}, 64'd0);
    pe_start = pe_cycles;
    apply_byte(8'h4E);
    tick(2);
    check("run_back_idle", 64'(pe_cycles - pe_start), 64'd0);

    $display("[TB] single stepping");
    apply_byte(8'h4C);
    send_word(32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'd0);
    tick(1);
    check("reload_prog_loaded", {63'd0, prog_loaded}, 64'd1);
    check("reload_clock_count", {32'd0, clock_count}, 64'd0);
    apply_byte(8'h53);
    pe_start = pe_cycles;
    for (int n = 0; n < 2; n++) begin
      apply_byte(8'h4E);
      check("step_pulse_on", {63'd0, pipe_enable}, 64'd1);
      check("step_flag_before", {63'd0, send_flag}, 64'd0);
      tick(1);
      check("step_pulse_off", {63'd0, pipe_enable}, 64'd0);
      check("step_flag_on", {63'd0, send_flag}, 64'd1);
      tick(2);
      check("step_flag_held", {63'd0, send_flag}, 64'd1);
      pulse_send_done();
      check("step_flag_clear", {63'd0, send_flag}, 64'd0);
    end
    check("step_pe_cycles", 64'(pe_cycles - pe_start), 64'd2);
    check("step_clock_count", {32'd0, clock_count}, 64'd2);
    apply_byte(8'h58);
    tick(1);
    check("step_ignore_pe", {63'd0, pipe_enable}, 64'd0);
    check("step_ignore_flag", {63'd0, send_flag}, 64'd0);

    halt = 1'b1;
    apply_byte(8'h4E);
    check("step_halt_no_pulse", {63'd0, pipe_enable}, 64'd0);
    check("step_halt_flag", {63'd0, send_flag}, 64'd1);
    halt = 1'b0;
    @(posedge clk);
    #1;
    rx_data = 8'h45;
    rx_done = 1'b1;
    send_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    send_done = 1'b0;
    check("coincide_flag_clear", {63'd0, send_flag}, 64'd0);
    apply_byte(8'h4E);
    check("coincide_still_step", {63'd0, pipe_enable}, 64'd1);
    halt = 1'b1;
    tick(1);
    check("halt_during_pulse_flag", {63'd0, send_flag}, 64'd1);
    check("halt_during_pulse_count", {32'd0, clock_count}, 64'd3);
    pulse_send_done();
    halt = 1'b0;
    pe_start = pe_cycles;
    apply_byte(8'h4E);
    tick(2);
    check("halted_step_to_idle", 64'(pe_cycles - pe_start), 64'd0);
    check("halted_step_flag", {63'd0, send_flag}, 64'd0);
    apply_byte(8'h53);
    apply_byte(8'h45);
    apply_byte(8'h4E);
    tick(2);
    check("exit_to_idle", 64'(pe_cycles - pe_start), 64'd0);

    $display("[TB] reset in the middle of a load");
    apply_byte(8'h4C);
    apply_byte(8'h12);
    apply_byte(8'h34);
    strobes_before = main_strobes;
    do_reset();
    tick(3);
    check("abort_no_strobe", 64'(main_strobes - strobes_before), 64'd0);
    check("abort_prog_loaded", {63'd0, prog_loaded}, 64'd0);
    check("abort_im_addr", {32'd0, im_addr}, 64'd0);
    apply_byte(8'h4C);
    send_word(32'hA1B2_C3D4, 1'b1, 1'b1, 32'd0, 32'd0);
    tick(1);
    check("abort_reload_not_done", {63'd0, prog_loaded}, 64'd0);

    $display("[TB] load hitting the end of a 4-word memory");
    do_reset();
    apply_byte(8'h4C);
    for (int i = 0; i < 4; i++) begin
      send_word(32'h1000_0001 + 32'(i), 1'b1, 1'b1, 32'(i), 32'(i));
    end
    tick(1);
    check("full_small_prog_loaded", {63'd0, s_prog_loaded}, 64'd1);
    check("full_small_im_addr", {32'd0, s_im_addr}, 64'd3);
    check("full_main_prog_loaded", {63'd0, prog_loaded}, 64'd0);
    check("full_main_im_addr", {32'd0, im_addr}, 64'd4);
    send_word(32'h1122_3344, 1'b1, 1'b0, 32'd4, 32'd0);
    tick(1);
    check("full_small_im_addr_hold", {32'd0, s_im_addr}, 64'd3);

    check("main_strobe_total", 64'(main_strobes), 64'(pushed_main));
    check("small_strobe_total", 64'(small_strobes), 64'(pushed_small));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
